// File: rtl/machine_mode_types_1_12_pkg.sv
// CLINT register offsets, reset values, bus FSM states and byte-lane merge helper.
// Shared by the CLINT top and its mtime counter.
package machine_mode_types_1_12_pkg;

  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = '1;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MT_LO,
    SEL_MT_HI
  } reg_sel_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/priv_1_12_clint_mtime.sv
// Prescaler and 64-bit mtime counter; a bus write to either half wins over the tick
// and restarts the prescaler. Exposes both current and next-state mtime.
module priv_1_12_clint_mtime
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [63:0] mtime,
  output logic [63:0] mtime_nxt
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          wrap;

  always_comb begin
    wrap    = (presc_q == PW'(PRESCALE - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    mtime_d = wrap ? mtime_q + 64'd1 : mtime_q;
    // The written half takes bus data, the other half holds its old value.
    if (wr_lo) begin
      mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wdata, byte_en)};
      presc_d = '0;
    end
    if (wr_hi) begin
      mtime_d = {merge_lanes(mtime_q[63:32], wdata, byte_en), mtime_q[31:0]};
      presc_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime     = mtime_q;
  assign mtime_nxt = mtime_d;

endmodule

// File: rtl/priv_1_12_clint.sv
// Machine-mode CLINT: msip, mtimecmp, mtime behind a one-cycle request/response bus.
// busy is high only in the request cycle; requests arriving during the response are dropped.
module priv_1_12_clint
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        byte_en,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              error,
  output logic              timer_int_m,
  output logic              soft_int_m,
  output logic              clear_timer_int_m,
  output logic              clear_soft_int_m
);

  bus_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        timer_q, timer_d;
  logic        clr_timer_q, clr_timer_d;
  logic        clr_soft_q, clr_soft_d;

  reg_sel_e    sel;
  logic        req, bad, wr_en;
  logic [31:0] rd_val;
  logic [63:0] mtime, mtime_nxt;

  // Offsets are word aligned, so any addr[1:0] != 0 falls through to SEL_NONE.
  always_comb begin
    sel = SEL_NONE;
    if      (addr == ADDR_W'(OFF_MSIP))        sel = SEL_MSIP;
    else if (addr == ADDR_W'(OFF_MTIMECMP_LO)) sel = SEL_CMP_LO;
    else if (addr == ADDR_W'(OFF_MTIMECMP_HI)) sel = SEL_CMP_HI;
    else if (addr == ADDR_W'(OFF_MTIME_LO))    sel = SEL_MT_LO;
    else if (addr == ADDR_W'(OFF_MTIME_HI))    sel = SEL_MT_HI;
  end

  assign req   = (state_q == BUS_IDLE) && (ren || wen);
  assign bad   = (sel == SEL_NONE);
  assign wr_en = req && wen && !bad;

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_MSIP:   rd_val = {31'b0, msip_q};
      SEL_CMP_LO: rd_val = mtimecmp_q[31:0];
      SEL_CMP_HI: rd_val = mtimecmp_q[63:32];
      SEL_MT_LO:  rd_val = mtime[31:0];
      SEL_MT_HI:  rd_val = mtime[63:32];
      default:    rd_val = '0;
    endcase
  end

  priv_1_12_clint_mtime #(
    .PRESCALE (PRESCALE)
  ) u_mtime (
    .CLK       (CLK),
    .RST       (RST),
    .wr_lo     (wr_en && (sel == SEL_MT_LO)),
    .wr_hi     (wr_en && (sel == SEL_MT_HI)),
    .wdata     (wdata),
    .byte_en   (byte_en),
    .mtime     (mtime),
    .mtime_nxt (mtime_nxt)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    error_d = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (ren || wen) begin
          state_d = BUS_RESP;
          error_d = bad;
          rdata_d = (ren && !bad) ? rd_val : '0;
        end
      end
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_en && (sel == SEL_MSIP) && byte_en[0]) msip_d = wdata[0];
    if (wr_en && (sel == SEL_CMP_LO))
      mtimecmp_d[31:0] = merge_lanes(mtimecmp_q[31:0], wdata, byte_en);
    if (wr_en && (sel == SEL_CMP_HI))
      mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], wdata, byte_en);
    // Compare next-state values so the interrupt tracks the registers it is derived from.
    timer_d     = (mtime_nxt >= mtimecmp_d);
    clr_timer_d = timer_q && !timer_d;
    clr_soft_d  = msip_q && !msip_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= BUS_IDLE;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      msip_q      <= 1'b0;
      mtimecmp_q  <= MTIMECMP_RST;
      timer_q     <= 1'b0;
      clr_timer_q <= 1'b0;
      clr_soft_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_q     <= timer_d;
      clr_timer_q <= clr_timer_d;
      clr_soft_q  <= clr_soft_d;
    end
  end

  assign busy              = req && !RST;
  assign rdata             = rdata_q;
  assign error             = error_q;
  assign timer_int_m       = timer_q;
  assign soft_int_m        = msip_q;
  assign clear_timer_int_m = clr_timer_q;
  assign clear_soft_int_m  = clr_soft_q;

endmodule
